// File: rtl/axi_bridge_pkg.sv
// Shared encodings for the cache-to-AXI bridge: client request types, AXI burst/size
// constants, FSM state enums and a helper that yields the line-offset width.
package axi_bridge_pkg;

  // Client request type encodings (rd_type / wr_type).
  localparam logic [2:0] RT_BYTE = 3'b000;
  localparam logic [2:0] RT_HALF = 3'b001;
  localparam logic [2:0] RT_WORD = 3'b010;
  localparam logic [2:0] RT_LINE = 3'b100;

  // AXI fixed fields.
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_LOCK   = 2'b00;
  localparam logic [3:0] AXI_CACHE  = 4'b0000;
  localparam logic [2:0] AXI_PROT   = 3'b000;

  typedef enum logic {
    ArIdle,
    ArAddr
  } ar_state_e;

  typedef enum logic [1:0] {
    WIdle,
    WSend,
    WResp
  } w_state_e;

  // Byte-offset bits within a cache line of 32-bit words.
  function automatic int unsigned line_off_bits(int unsigned line_words);
    return $clog2(line_words * 4);
  endfunction

endpackage

// File: rtl/axi_cache_bridge_mc_if.sv
// AXI3 bus bundle (AR, R, AW, W, B channels) between the cache bridge and the interconnect.
// master: the bridge side; slave: the interconnect / memory model side.
interface axi_cache_bridge_mc_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
);
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [1:0]        awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;

  logic [ID_W-1:0]   wid;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at ptr_i and wraps; the caller owns
// and advances the pointer.
//   req_i       per-requester request
//   ptr_i       highest-priority index this cycle
//   gnt_o       one-hot grant
//   gnt_idx_o   index of the granted requester
//   gnt_valid_o some requester was granted
module rr_arbiter #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            gnt_valid_o
);

  int unsigned cand;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!gnt_valid_o && req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IdxW'(cand);
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_cache_bridge_mc.sv
// AXI3 master bridge: NUM_RD cache read clients plus one write-back client onto one AXI port.
// Reads are arbitrated round-robin, one outstanding per client (ARID = client index); writes
// use AWID = WID = NUM_RD. Reads hitting the line of an in-flight write are held off.
// Ports:
//   aclk, aresetn                          clock, async active-low reset
//   rd_req/rd_type/rd_addr -> rd_rdy       read clients (type 000 b, 001 h, 010 w, 100 line)
//   ret_valid/ret_last/ret_data            read return, routed by rid
//   wr_req/wr_type/wr_addr/wr_wstrb/wr_data -> wr_rdy   write-back client
//   axi                                    AXI3 master port
// Optional: define AXI_BRIDGE_PERF_EN to add perf_rd_cnt / perf_wr_cnt / perf_stall_cnt.
module axi_cache_bridge_mc
  import axi_bridge_pkg::*;
#(
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ID_W       = 4
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [NUM_RD-1:0]            rd_req,
  input  logic [3*NUM_RD-1:0]          rd_type,
  input  logic [ADDR_W*NUM_RD-1:0]     rd_addr,
  output logic [NUM_RD-1:0]            rd_rdy,
  output logic [NUM_RD-1:0]            ret_valid,
  output logic                         ret_last,
  output logic [DATA_W-1:0]            ret_data,
  input  logic                         wr_req,
  input  logic [2:0]                   wr_type,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [3:0]                   wr_wstrb,
  input  logic [DATA_W*LINE_WORDS-1:0] wr_data,
  output logic                         wr_rdy,
`ifdef AXI_BRIDGE_PERF_EN
  output logic [31:0]                  perf_rd_cnt,
  output logic [31:0]                  perf_wr_cnt,
  output logic [31:0]                  perf_stall_cnt,
`endif
  axi_cache_bridge_mc_if.master        axi
);

  localparam int unsigned OffW   = line_off_bits(LINE_WORDS);
  localparam int unsigned LineW  = ADDR_W - OffW;
  localparam int unsigned IdxW   = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int unsigned WcntW  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  // AR side state
  ar_state_e             ar_state_q, ar_state_d;
  logic [ID_W-1:0]       arid_q, arid_d;
  logic [ADDR_W-1:0]     araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic                  arvalid_q, arvalid_d;
  logic [NUM_RD-1:0]     outstanding_q, outstanding_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;

  // W side state
  w_state_e                     w_state_q, w_state_d;
  logic [ADDR_W-1:0]            awaddr_q, awaddr_d;
  logic [7:0]                   awlen_q, awlen_d;
  logic [2:0]                   awsize_q, awsize_d;
  logic [3:0]                   wstrb_q, wstrb_d;
  logic [DATA_W*LINE_WORDS-1:0] line_q, line_d;
  logic [WcntW-1:0]             wcnt_q, wcnt_d;
  logic                         awvalid_q, awvalid_d;
  logic                         wvalid_q, wvalid_d;
  logic                         aw_done_q, aw_done_d;
  logic                         w_done_q, w_done_d;
  logic                         bready_q, bready_d;

  logic [NUM_RD-1:0] hazard, eligible, gnt;
  logic [IdxW-1:0]   gnt_idx;
  logic              gnt_valid;
  logic [2:0]        gtype;
  logic              wr_fire, r_last_fire, aw_hs, w_hs, w_last_hs;
  logic              unused_axi;

  assign unused_axi = ^{axi.rresp, axi.bid, axi.bresp};

  // ---------------- Hazard and eligibility ----------------
  assign wr_rdy  = (w_state_q == WIdle) && aresetn;
  assign wr_fire = wr_req && wr_rdy;

  always_comb begin
    hazard = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      // Busy write line, or a write being accepted into the same line this cycle.
      hazard[i] = ((w_state_q != WIdle) &&
                   (rd_addr[ADDR_W*i+OffW +: LineW] == awaddr_q[ADDR_W-1:OffW])) ||
                  (wr_fire && (rd_addr[ADDR_W*i+OffW +: LineW] == wr_addr[ADDR_W-1:OffW]));
    end
  end

  // Uses the pre-clear outstanding flag so a same-cycle rlast cannot re-grant its client.
  assign eligible = rd_req & ~outstanding_q & ~hazard;

  rr_arbiter #(
    .N    (NUM_RD),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .req_i       (eligible),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  assign rd_rdy = ((ar_state_q == ArIdle) && aresetn) ? gnt : '0;

  // ---------------- R pass-through ----------------
  assign axi.rready = 1'b1;
  assign ret_data   = axi.rdata;
  assign ret_last   = axi.rvalid & axi.rlast;
  assign r_last_fire = axi.rvalid & axi.rlast;

  always_comb begin
    ret_valid = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ret_valid[i] = axi.rvalid && (axi.rid == ID_W'(i));
    end
  end

  // ---------------- AR FSM ----------------
  always_comb begin
    ar_state_d    = ar_state_q;
    arid_d        = arid_q;
    araddr_d      = araddr_q;
    arlen_d       = arlen_q;
    arsize_d      = arsize_q;
    arvalid_d     = arvalid_q;
    rr_ptr_d      = rr_ptr_q;
    outstanding_d = outstanding_q;
    gtype         = rd_type[3*int'(gnt_idx) +: 3];

    // Beats with rid >= NUM_RD match no client and are dropped here.
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (r_last_fire && (axi.rid == ID_W'(i))) outstanding_d[i] = 1'b0;
    end

    unique case (ar_state_q)
      ArIdle: begin
        if (gnt_valid) begin
          arid_d        = ID_W'(gnt_idx);
          araddr_d      = rd_addr[ADDR_W*int'(gnt_idx) +: ADDR_W];
          arlen_d       = (gtype == RT_LINE) ? 8'(LINE_WORDS - 1) : 8'd0;
          arsize_d      = (gtype == RT_LINE) ? SIZE_WORD : {1'b0, gtype[1:0]};
          outstanding_d = outstanding_d | gnt;
          rr_ptr_d      = IdxW'((int'(gnt_idx) + 1) % NUM_RD);
          arvalid_d     = 1'b1;
          ar_state_d    = ArAddr;
        end
      end
      ArAddr: begin
        if (axi.arready) begin
          arvalid_d  = 1'b0;
          ar_state_d = ArIdle;
        end
      end
      default: ar_state_d = ArIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_state_q    <= ArIdle;
      arid_q        <= '0;
      araddr_q      <= '0;
      arlen_q       <= '0;
      arsize_q      <= '0;
      arvalid_q     <= 1'b0;
      rr_ptr_q      <= '0;
      outstanding_q <= '0;
    end else begin
      ar_state_q    <= ar_state_d;
      arid_q        <= arid_d;
      araddr_q      <= araddr_d;
      arlen_q       <= arlen_d;
      arsize_q      <= arsize_d;
      arvalid_q     <= arvalid_d;
      rr_ptr_q      <= rr_ptr_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = BURST_INCR;
  assign axi.arlock  = AXI_LOCK;
  assign axi.arcache = AXI_CACHE;
  assign axi.arprot  = AXI_PROT;
  assign axi.arvalid = arvalid_q;

  // ---------------- Write FSM ----------------
  assign aw_hs     = awvalid_q & axi.awready;
  assign w_hs      = wvalid_q & axi.wready;
  assign w_last_hs = w_hs & axi.wlast;

  always_comb begin
    w_state_d = w_state_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    awsize_d  = awsize_q;
    wstrb_d   = wstrb_q;
    line_d    = line_q;
    wcnt_d    = wcnt_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bready_d  = bready_q;

    unique case (w_state_q)
      WIdle: begin
        if (wr_req) begin
          awaddr_d  = wr_addr;
          awlen_d   = (wr_type == RT_LINE) ? 8'(LINE_WORDS - 1) : 8'd0;
          awsize_d  = (wr_type == RT_LINE) ? SIZE_WORD : {1'b0, wr_type[1:0]};
          wstrb_d   = (wr_type == RT_LINE) ? 4'hF : wr_wstrb;
          line_d    = wr_data;
          wcnt_d    = '0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = WSend;
        end
      end
      WSend: begin
        // AW and W progress independently; either may finish first.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          if (axi.wlast) begin
            wvalid_d = 1'b0;
            w_done_d = 1'b1;
          end else begin
            wcnt_d = WcntW'(wcnt_q + 1'b1);
          end
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_last_hs)) begin
          bready_d  = 1'b1;
          w_state_d = WResp;
        end
      end
      WResp: begin
        if (axi.bvalid) begin
          bready_d  = 1'b0;
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= WIdle;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      wstrb_q   <= '0;
      line_q    <= '0;
      wcnt_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      awsize_q  <= awsize_d;
      wstrb_q   <= wstrb_d;
      line_q    <= line_d;
      wcnt_q    <= wcnt_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bready_q  <= bready_d;
    end
  end

  assign axi.awid    = ID_W'(NUM_RD);
  assign axi.awaddr  = awaddr_q;
  assign axi.awlen   = awlen_q;
  assign axi.awsize  = awsize_q;
  assign axi.awburst = BURST_INCR;
  assign axi.awlock  = AXI_LOCK;
  assign axi.awcache = AXI_CACHE;
  assign axi.awprot  = AXI_PROT;
  assign axi.awvalid = awvalid_q;
  assign axi.wid     = ID_W'(NUM_RD);
  assign axi.wdata   = line_q[DATA_W*int'(wcnt_q) +: DATA_W];
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = (8'(wcnt_q) == awlen_q);
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

`ifdef AXI_BRIDGE_PERF_EN
  logic [31:0] perf_rd_q, perf_rd_d, perf_wr_q, perf_wr_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_rd_d    = perf_rd_q + {31'd0, axi.arvalid & axi.arready};
    perf_wr_d    = perf_wr_q + {31'd0, axi.bvalid & axi.bready};
    // Stalled purely by a line hazard: requesting, not outstanding, but hazarded.
    perf_stall_d = perf_stall_q + {31'd0, |(rd_req & ~outstanding_q & hazard)};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      perf_rd_q    <= '0;
      perf_wr_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_rd_q    <= perf_rd_d;
      perf_wr_q    <= perf_wr_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_rd_cnt    = perf_rd_q;
  assign perf_wr_cnt    = perf_wr_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: doc/axi_cache_bridge_mc.md
Name: axi_cache_bridge_mc

Overview:
Parametrised AXI3 master bridge between N cache read clients plus one cache write-back client and a single AXI slave port. It arbitrates reads round-robin and allows one outstanding read per client, using the client index as ARID. It issues single-beat or full-line INCR bursts for reads and writes, and blocks any read whose line matches an in-flight write (RAW hazard). It sits between icache/dcache and the SoC AXI interconnect. It replaces the fixed two-client, single-outstanding bridge.

Parameters:
NUM_RD, 2, number of read clients (1..8); client i uses ARID=i.
LINE_WORDS, 4, words per cache line (power of 2, 1..16).
ADDR_W, 32, address width.
DATA_W, 32, AXI and client data width (fixed 32).
ID_W, 4, AXI ID width; NUM_RD must be < 2**ID_W.

Ports:
aclk  in  1  clock, rising edge.
aresetn  in  1  asynchronous active-low reset.
rd_req  in  NUM_RD  per-client read request.
rd_type  in  3*NUM_RD  per-client type: 000 byte, 001 half, 010 word, 100 line.
rd_addr  in  ADDR_W*NUM_RD  per-client start address.
rd_rdy  out  NUM_RD  per-client request accepted this cycle.
ret_valid  out  NUM_RD  return beat for client i.
ret_last  out  1  final beat of the burst.
ret_data  out  DATA_W  return data, shared by all clients.
wr_req  in  1  write request.
wr_type  in  3  same encoding as rd_type.
wr_addr  in  ADDR_W  write start address.
wr_wstrb  in  4  byte strobes for single writes.
wr_data  in  DATA_W*LINE_WORDS  line data; word 0 in LSBs; single writes use word 0.
wr_rdy  out  1  write accepted this cycle.
AXI AR: arid, araddr, arlen[7:0], arsize[2:0], arburst, arlock, arcache, arprot, arvalid (outputs); arready (input).
AXI R: rid, rdata, rresp, rlast, rvalid (inputs); rready (output).
AXI AW: awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid (outputs); awready (input).
AXI W: wid, wdata, wstrb, wlast, wvalid (outputs); wready (input).
AXI B: bid, bresp, bvalid (inputs); bready (output).

Behaviour:
- Constants: arburst/awburst=01; lock, cache, prot=0; awid=wid=NUM_RD.
- Reset (async assert, sync release): AR_IDLE, W_IDLE, outstanding flags cleared, RR pointer=0, all AXI address/data regs 0. After reset: arvalid=awvalid=wvalid=bready=0, rready=1, rd_rdy=0, wr_rdy=0 while in reset. Reset mid-burst abandons the transaction; the slave must be reset together with the bridge.
- Read eligibility: client i is eligible when rd_req[i] & ~outstanding[i] & ~hazard_i.
- Line hazard: hazard_i is set when rd_addr[i] line bits [ADDR_W-1:log2(LINE_WORDS*4)] equal the awaddr line bits and the write FSM is not W_IDLE. It is also set when they equal the wr_addr line bits and wr_req&wr_rdy fire in the same cycle.
- AR FSM, AR_IDLE:
  - Grant the first eligible client starting at RR pointer, wrapping.
  - rd_rdy[grant]=1, combinational, only in AR_IDLE.
  - On grant: latch arid=i, araddr, arlen (line: LINE_WORDS-1, else 0), arsize (line: 010, else rd_type[1:0]).
  - Set outstanding[i]; RR pointer = i+1 mod NUM_RD.
  - Go to AR_ADDR.
- AR FSM, AR_ADDR: arvalid=1 and fields held stable; on arready go to AR_IDLE. Minimum one idle cycle between AR issues.
- R path:
  - rready is constant 1; zero-latency pass-through.
  - ret_valid[i]=rvalid&(rid==i); ret_data=rdata; ret_last=rvalid&rlast.
  - outstanding[rid] clears on rvalid&rlast.
  - An R beat with rid>=NUM_RD is dropped. rresp is ignored.
- Write FSM, W_IDLE:
  - wr_rdy=1.
  - On wr_req: latch awaddr; awlen (line: LINE_WORDS-1, else 0); awsize (line: 010, else wr_type[1:0]); the line buffer; wstrb (line: 4'hF, else wr_wstrb).
  - Go to W_SEND.
- Write FSM, W_SEND:
  - awvalid stays high until awready; wvalid stays high until all beats are sent. AW and W are independent, and W may complete before AW.
  - A beat counter wcnt (log2 LINE_WORDS bits) selects wdata; wlast=(wcnt==awlen).
  - Go to W_RESP when both the AW handshake and the last-W handshake have occurred; both may occur in the same cycle.
- Write FSM, W_RESP: bready=1; on bvalid go to W_IDLE and release the hazard. bresp is ignored.
- Simultaneous events:
  - A read grant and a write accept in the same cycle are both allowed, subject to the same-cycle hazard check.
  - An R last beat and an AR grant of the same client in one cycle: the grant uses the pre-clear flag and is denied.

Optional Feature:
AXI_BRIDGE_PERF_EN.
- Defined: adds outputs perf_rd_cnt[31:0], perf_wr_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_rd_cnt increments on each AR handshake.
  - perf_wr_cnt increments on each B handshake.
  - perf_stall_cnt increments each cycle where some rd_req[i] is high but blocked only by a hazard.
  - All three counters reset to 0 and wrap at 2^32.
- Undefined: the ports and logic are absent, and the remaining behaviour is identical.

Decomposition:
- Package axi_bridge_pkg holds: burst/size/type encodings (RT_BYTE, RT_HALF, RT_WORD, RT_LINE), the AR and W state enums, AXI fixed-field constants, and a line-offset-bits function.
- Sub-module rr_arbiter (NUM_RD-wide round-robin with an external pointer advance) is natural to split out.

Test Plan:
1. Reset: assert aresetn=0 mid-burst -> all valids 0 immediately, rready=1, outstanding flags clear, next request serviced normally.
2. Line reads, NUM_RD=2, LINE_WORDS=4:
   - Stimulus: client0 and client1 both request line reads at 0x1000 and 0x2000.
   - Required: client0 granted first (arid=0, arlen=3), then client1 (arid=1); interleaved R beats route to ret_valid by rid; ret_last on the 4th beat of each.
3. Line write then hazard read:
   - Stimulus: line write to 0x3000 with data words 0xA0..0xA3; then a read of 0x3008.
   - Required: awlen=3, wstrb=F, wlast on the 4th beat; the read's rd_rdy stays 0 until the cycle after the B handshake, then it is granted.
4. Byte write: wr_type=000, addr 0x4001, wstrb=0010 -> awsize=000, awlen=0, wlast=1 on the single beat.
5. W before AW: hold awready=0 for 5 cycles with wready=1 -> all W beats complete, FSM waits in W_SEND, W_RESP entered only after awready.
6. Same-client re-request: client0 rd_req held high while its read is outstanding -> rd_rdy[0]=0 until the cycle after rlast; client1 is still granted in between.
